// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, NOP address and arbiter state type
package sdram_pkg;

  // {CKE, CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [4:0]  CMD_NOP   = 5'b10111;
  localparam logic [4:0]  CMD_ACT   = 5'b10011;
  localparam logic [4:0]  CMD_READ  = 5'b10101;
  localparam logic [4:0]  CMD_WRITE = 5'b10100;
  localparam logic [4:0]  CMD_PREC  = 5'b10010;
  localparam logic [4:0]  CMD_REF   = 5'b10001;
  localparam logic [11:0] NOP_ADDR  = 12'h400;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARB,
    ST_REF,
    ST_WRITE,
    ST_READ
  } arb_state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// rtl/sdram_ref_timer.sv - free-running refresh interval counter with sticky refresh-pending flag
module sdram_ref_timer #(
  parameter int REF_PERIOD = 780
) (
  input  logic S_CLK,
  input  logic RST_N,
  input  logic enable,
  input  logic ref_clr,
  output logic ref_pend
);

  localparam int CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = enable && (cnt == CW'(REF_PERIOD - 1));

  // A wrap landing on the same edge as the clear keeps the request pending.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt      <= '0;
      ref_pend <= 1'b0;
    end else begin
      if (enable) cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap)         ref_pend <= 1'b1;
      else if (ref_clr) ref_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - SDRAM command bus arbiter: init/refresh/write/read grants and pin mux
// ARB_ROUND_ROBIN_EN: alternate write/read when both are pending (refresh keeps top priority)
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int REF_PERIOD = 780
) (
  input  logic        S_CLK,
  input  logic        RST_N,
  input  logic        init_done,
  input  logic [4:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic        write_ack,
  input  logic        read_ack,
  input  logic        ref_ack,
  input  logic [4:0]  write_cmd,
  input  logic [11:0] write_addr,
  input  logic [4:0]  read_cmd,
  input  logic [11:0] read_addr,
  input  logic [4:0]  ref_cmd,
  input  logic [11:0] ref_addr,
  output logic        write_en,
  output logic        read_en,
  output logic        ref_en,
  output logic [4:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic        busy
);

  arb_state_e state, state_nxt;
  logic       ref_pend;
  logic       ref_clr;

  sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref_timer (
    .S_CLK    (S_CLK),
    .RST_N    (RST_N),
    .enable   (init_done),
    .ref_clr  (ref_clr),
    .ref_pend (ref_pend)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_op_wr;

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N)                                       last_op_wr <= 1'b0;
    else if (state == ST_ARB && state_nxt == ST_WRITE) last_op_wr <= 1'b1;
    else if (state == ST_ARB && state_nxt == ST_READ)  last_op_wr <= 1'b0;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  if (init_done) state_nxt = ST_ARB;
      ST_ARB: begin
        if (ref_pend) state_nxt = ST_REF;
        else if (wr_req && rd_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_nxt = last_op_wr ? ST_READ : ST_WRITE;
`else
          state_nxt = ST_WRITE;
`endif
        end
        else if (wr_req) state_nxt = ST_WRITE;
        else if (rd_req) state_nxt = ST_READ;
      end
      ST_REF:   if (ref_ack)   state_nxt = ST_ARB;
      ST_WRITE: if (write_ack) state_nxt = ST_ARB;
      ST_READ:  if (read_ack)  state_nxt = ST_ARB;
      default:  state_nxt = ST_INIT;
    endcase
  end

  assign ref_clr = (state == ST_ARB) && (state_nxt == ST_REF);

  // Grants and busy are registered from the next state so they move on the same edge as the FSM.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_INIT;
      write_en <= 1'b0;
      read_en  <= 1'b0;
      ref_en   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      write_en <= (state_nxt == ST_WRITE);
      read_en  <= (state_nxt == ST_READ);
      ref_en   <= (state_nxt == ST_REF);
      busy     <= (state_nxt != ST_ARB);
    end
  end

  always_comb begin
    sdram_cmd  = init_cmd;
    sdram_addr = init_addr;
    case (state)
      ST_ARB:   begin sdram_cmd = CMD_NOP;   sdram_addr = NOP_ADDR;   end
      ST_REF:   begin sdram_cmd = ref_cmd;   sdram_addr = ref_addr;   end
      ST_WRITE: begin sdram_cmd = write_cmd; sdram_addr = write_addr; end
      ST_READ:  begin sdram_cmd = read_cmd;  sdram_addr = read_addr;  end
      default:  begin sdram_cmd = init_cmd;  sdram_addr = init_addr;  end
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - table-driven scoreboard bench for sdram_arbiter (REF_PERIOD=50)
module tb_sdram_arbiter;

  localparam int          REF_PERIOD = 50;
  localparam logic [4:0]  INIT_CMD   = 5'b10010;
  localparam logic [11:0] INIT_ADDR  = 12'h0AA;
  localparam logic [4:0]  WR_CMD     = 5'b10100;
  localparam logic [11:0] WR_ADDR    = 12'h111;
  localparam logic [4:0]  RD_CMD     = 5'b10101;
  localparam logic [11:0] RD_ADDR    = 12'h222;
  localparam logic [4:0]  RF_CMD     = 5'b10001;
  localparam logic [11:0] RF_ADDR    = 12'h333;
  localparam logic [4:0]  NOP_CMD    = 5'b10111;
  localparam logic [11:0] NOP_ADR    = 12'h400;

  logic        S_CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        init_done = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic        write_ack = 1'b0, read_ack = 1'b0, ref_ack = 1'b0;
  logic        write_en, read_en, ref_en, busy;
  logic [4:0]  sdram_cmd;
  logic [11:0] sdram_addr;

  always #5 S_CLK = ~S_CLK;

  sdram_arbiter #(.REF_PERIOD(REF_PERIOD)) dut (
    .S_CLK      (S_CLK),
    .RST_N      (RST_N),
    .init_done  (init_done),
    .init_cmd   (INIT_CMD),
    .init_addr  (INIT_ADDR),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .write_ack  (write_ack),
    .read_ack   (read_ack),
    .ref_ack    (ref_ack),
    .write_cmd  (WR_CMD),
    .write_addr (WR_ADDR),
    .read_cmd   (RD_CMD),
    .read_addr  (RD_ADDR),
    .ref_cmd    (RF_CMD),
    .ref_addr   (RF_ADDR),
    .write_en   (write_en),
    .read_en    (read_en),
    .ref_en     (ref_en),
    .sdram_cmd  (sdram_cmd),
    .sdram_addr (sdram_addr),
    .busy       (busy)
  );

  typedef enum int {S_INIT, S_ARB, S_REF, S_WR, S_RD} exp_st_e;

  typedef struct {
    logic    idn, wr, rd, wa, ra, fa;
    exp_st_e st;
  } vec_t;

  vec_t    vecs[$];
  exp_st_e sb_st[$];
  int      sb_id[$];
  int      errors = 0;
  int      checks = 0;

  function automatic void add(logic idn, logic wr, logic rd, logic wa, logic ra, logic fa, exp_st_e st);
    vec_t v;
    v.idn = idn; v.wr = wr; v.rd = rd; v.wa = wa; v.ra = ra; v.fa = fa; v.st = st;
    vecs.push_back(v);
  endfunction

  function automatic void add_n(int n, logic idn, logic wr, logic rd, exp_st_e st);
    for (int i = 0; i < n; i++) add(idn, wr, rd, 1'b0, 1'b0, 1'b0, st);
  endfunction

  // {write_en, read_en, ref_en, busy, cmd, addr} expected for a given state
  function automatic logic [20:0] expect_of(exp_st_e st, logic in_reset);
    logic [2:0]  en;
    logic        b;
    logic [4:0]  c;
    logic [11:0] a;
    en = 3'b000; b = 1'b1; c = INIT_CMD; a = INIT_ADDR;
    case (st)
      S_INIT: b = !in_reset;
      S_ARB:  begin b = 1'b0; c = NOP_CMD; a = NOP_ADR; end
      S_REF:  begin en = 3'b001; c = RF_CMD; a = RF_ADDR; end
      S_WR:   begin en = 3'b100; c = WR_CMD; a = WR_ADDR; end
      S_RD:   begin en = 3'b010; c = RD_CMD; a = RD_ADDR; end
      default: ;
    endcase
    return {en, b, c, a};
  endfunction

  task automatic check(string name, int id, logic [20:0] exp);
    logic [20:0] act;
    act = {write_en, read_en, ref_en, busy, sdram_cmd, sdram_addr};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: en(w,r,f)/busy/cmd/addr got %b/%b/%b/%h expected %b/%b/%b/%h",
               name, id, act[20:18], act[17], act[16:12], act[11:0],
               exp[20:18], exp[17], exp[16:12], exp[11:0]);
    end
  endtask

  task automatic run_table(string name);
    foreach (vecs[i]) begin
      @(negedge S_CLK);
      if (sb_st.size() > 0) check(name, sb_id.pop_front(), expect_of(sb_st.pop_front(), 1'b0));
      init_done = vecs[i].idn;
      wr_req    = vecs[i].wr;
      rd_req    = vecs[i].rd;
      write_ack = vecs[i].wa;
      read_ack  = vecs[i].ra;
      ref_ack   = vecs[i].fa;
      sb_st.push_back(vecs[i].st);
      sb_id.push_back(i);
    end
    @(negedge S_CLK);
    while (sb_st.size() > 0) check(name, sb_id.pop_front(), expect_of(sb_st.pop_front(), 1'b0));
    {wr_req, rd_req, write_ack, read_ack, ref_ack} = '0;
    vecs.delete();
  endtask

  task automatic do_reset(string name);
    RST_N = 1'b0;
    #1;
    check(name, 0, expect_of(S_INIT, 1'b1));
    {init_done, wr_req, rd_req, write_ack, read_ack, ref_ack} = '0;
    @(negedge S_CLK);
    @(negedge S_CLK);
    check(name, 1, expect_of(S_INIT, 1'b1));
    RST_N = 1'b1;
  endtask

  initial begin
    @(negedge S_CLK);
    do_reset("reset");

    // Init hold, single read with stray acks, write/read contention.
    add_n(100, 1'b0, 1'b0, 1'b0, S_INIT);
    add(1, 0, 0, 0, 0, 0, S_ARB);
    add(1, 0, 1, 0, 0, 0, S_RD);
    for (int k = 3; k <= 13; k++) add(1, 0, 1, (k == 8), 0, (k == 6), S_RD);
    add(1, 0, 0, 0, 1, 0, S_ARB);
    add(1, 0, 0, 0, 0, 0, S_ARB);
    add(1, 1, 1, 0, 0, 0, S_WR);
    for (int k = 17; k <= 19; k++) add(1, 1, 1, 0, 0, 0, S_WR);
    add(1, 0, 1, 1, 0, 0, S_ARB);
`ifdef ARB_ROUND_ROBIN_EN
    add(1, 1, 1, 0, 0, 0, S_RD);
    add(1, 1, 0, 0, 1, 0, S_ARB);
    add(1, 1, 0, 0, 0, 0, S_WR);
    add(1, 0, 0, 1, 0, 0, S_ARB);
`else
    add(1, 1, 1, 0, 0, 0, S_WR);
    add(1, 0, 1, 1, 0, 0, S_ARB);
    add(1, 0, 1, 0, 0, 0, S_RD);
    add(1, 0, 0, 0, 1, 0, S_ARB);
`endif
    add(1, 0, 0, 0, 0, 0, S_ARB);
    run_table("basic");

    // Refresh across reads: wrap mid-read, set-wins-over-clear, double wrap counted once.
    @(negedge S_CLK);
    do_reset("reset2");
    add(1, 0, 0, 0, 0, 0, S_ARB);
    for (int k = 2; k <= 98; k++) add(1, (k >= 40), 1, 0, 0, 0, S_RD);
    add(1, 1, 0, 0, 1, 0, S_ARB);
    add(1, 1, 0, 0, 0, 0, S_REF);
    add(1, 1, 0, 0, 0, 0, S_REF);
    add(1, 1, 0, 0, 0, 1, S_ARB);
    add(1, 1, 0, 0, 0, 0, S_REF);
    add(1, 1, 0, 0, 0, 1, S_ARB);
    add(1, 1, 0, 0, 0, 0, S_WR);
    add(1, 0, 0, 1, 0, 0, S_ARB);
    add_n(95, 1'b1, 1'b0, 1'b1, S_RD);
    add(1, 0, 0, 0, 1, 0, S_ARB);
    add(1, 0, 0, 0, 0, 0, S_REF);
    add(1, 0, 0, 0, 0, 1, S_ARB);
    add_n(6, 1'b1, 1'b0, 1'b0, S_ARB);
    run_table("refresh");

    // Reset in the middle of a write grant, then the timer must restart from zero.
    @(negedge S_CLK);
    do_reset("reset3");
    add(1, 0, 0, 0, 0, 0, S_ARB);
    add(1, 1, 0, 0, 0, 0, S_WR);
    add(1, 1, 0, 0, 0, 0, S_WR);
    run_table("pre_rst");
    wr_req = 1'b1;
    init_done = 1'b1;
    do_reset("mid_grant_rst");
    add_n(50, 1'b1, 1'b0, 1'b0, S_ARB);
    add(1, 0, 0, 0, 0, 0, S_REF);
    add(1, 0, 0, 0, 0, 1, S_ARB);
    run_table("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter REF_PERIOD, default 780: S_CLK cycles between refresh requests (7.8 us at 100 MHz).
REQ-002 SHALL have reset RST_N, asynchronous, active-low, and clock S_CLK.
REQ-003 S_CLK  in  1  system clock.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 init_done  in  1  power-up init sequence complete (level).
REQ-006 init_cmd / init_addr  in  5/12  init sequencer bus.
REQ-007 wr_req / rd_req  in  1  write/read burst request (level, held until serviced).
REQ-008 write_ack / read_ack / ref_ack  in  1  one-cycle end-of-operation pulses from the sequencers.
REQ-009 write_cmd / write_addr, read_cmd / read_addr, ref_cmd / ref_addr  in  5/12  sequencer buses.
REQ-010 write_en / read_en / ref_en  out  1  grant to the sequencer (level).
REQ-011 sdram_cmd  out  5  {CKE,CS_N,RAS_N,CAS_N,WE_N} to the pins.
REQ-012 sdram_addr  out  12  address to the pins.
REQ-013 busy  out  1  high in any non-ARB state.

Function
REQ-014 FSM states: INIT, ARB, REF, WRITE, READ.
REQ-015 INIT: sdram_cmd/addr = init_cmd/init_addr; no grant asserted; ARB on the cycle after init_done is sampled high.
REQ-016 Refresh timer: counts 0..REF_PERIOD-1 only after init_done, wraps, sets ref_pend on wrap; ref_pend clears on REF entry.
REQ-017 ARB fixed priority: ref_pend > wr_req > rd_req; transition on the next edge; matching *_en registered high in the same edge.
REQ-018 Grant level stays high until the matching ack is sampled; *_en drops on that edge; FSM returns to ARB.
REQ-019 One grant at a time, always; acks not matching the current state are ignored.
REQ-020 Minimum 1 ARB cycle between consecutive grants (back-to-back requests: grant, ack, ARB, next grant).
REQ-021 Output mux, combinational from state: REF->ref bus; WRITE->write bus; READ->read bus; ARB->NOP 5'b10111, addr 12'h400.
REQ-022 Timer wrap during WRITE/READ: ref_pend latches, serviced at next ARB ahead of any pending rd/wr.
REQ-023 Second wrap while ref_pend already set: ref_pend stays 1, no counting of missed refreshes.
REQ-024 Timer wrap and ref_pend clear on the same edge: set wins.

Reset
REQ-025 On RST_N low: state INIT, all *_en 0, busy 0, timer 0, ref_pend 0; sdram_cmd/addr follow the init bus.
REQ-026 Reset mid-grant drops the grant immediately (async); no ack is awaited.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN defined: when wr_req and rd_req are both pending in ARB, grant the one not served last (last_op flag, reset = read). Refresh still has top priority.
REQ-028 Macro undefined: strict write-over-read priority per REQ-017; last_op flag absent.

Structure
REQ-029 Shared package sdram_pkg: CMD_NOP/ACT/READ/WRITE/PREC/REF 5-bit constants, NOP address 12'h400, FSM state typedef.
REQ-030 Refresh timer (counter + ref_pend) SHALL be sub-module sdram_ref_timer; mux and FSM in sdram_arbiter.

Verification
REQ-031 init_done=0 for 100 cycles, init_cmd=5'b10010 -> sdram_cmd=5'b10010, all *_en=0; init_done=1 -> busy=0 (ARB) 1 cycle later.
REQ-032 rd_req=1, read_ack after 12 cycles -> read_en high for exactly 12 cycles; sdram_cmd tracks read_cmd; then NOP/12'h400.
REQ-033 wr_req=rd_req=1 together -> write_en first; after write_ack, 1 ARB cycle, then read_en (macro undefined); with macro, second pair of requests -> read first.
REQ-034 REF_PERIOD=50, read grant spanning timer wrap -> ref_en asserts one cycle after read_ack+ARB, before a pending wr_req.
REQ-035 RST_N low during write_en -> write_en=0 same cycle, sdram_cmd=init bus, timer 0.
REQ-036 Stray ref_ack pulse during READ -> ignored, read_en stays 1.
